uart_frame_tx: RTL and testbench

Parametrised UART transmitter with an input byte FIFO. It replaces the fixed-string, single-format transmitter in the status/reporting path. Upstream logic pushes arbitrary message characters (for example "NODE1", "SI-W-F...-#") over a valid/ready handshake. The block serialises them LSB-first with configurable data width, parity and stop bits, streams frames back-to-back, and signals end-of-stream.

---
 rtl/uart_frame_tx.sv | 217 +++++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// uart_frame_tx
//   UART transmitter with an input byte FIFO. Characters pushed over a
//   valid/ready handshake are serialised LSB-first as
//   start / DATA_BITS data / optional parity / STOP_BITS stop. Queued
//   characters go out back-to-back with no idle gap, and a one-cycle done
//   pulse marks the end of the stream.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-low
//   in_data     character to transmit
//   in_valid    in_data valid
//   in_ready    FIFO can accept (not full)
//   tx          serial line, idles high
//   busy        high whenever the transmitter is not idle
//   done        one-cycle pulse on the first idle cycle after a stream
//   fifo_level  current FIFO occupancy
module uart_frame_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);
  localparam logic [AW:0]      LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Control state (reset)
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               stop_q, stop_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        level_q, level_d;

  // Datapath state (no reset)
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic bit_end;
  logic fifo_nonempty;

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == 2) ? ~(^d) : (^d);
  endfunction

  assign in_ready      = (level_q != LEVEL_FULL);
  assign push          = in_valid && in_ready;
  assign fifo_nonempty = (level_q != '0);
  assign bit_end       = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = bit_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    stop_d   = stop_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
    shreg_d  = shreg_q;
    par_d    = par_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    pop      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (fifo_nonempty) pop = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            // shreg_q[0] is on the line now; bit [1] goes out next.
            idx_d   = idx_q + 1'b1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            // Decision uses the registered level, so a push landing on
            // this same edge is picked up from IDLE one cycle later.
            if (fifo_nonempty) begin
              pop = 1'b1;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
              done_d  = 1'b1;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (pop) begin
      state_d  = S_START;
      cnt_d    = '0;
      tx_d     = 1'b0;
      shreg_d  = mem_q[rd_ptr_q];
      par_d    = frame_parity(mem_q[rd_ptr_q]);
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
    shreg_q <= shreg_d;
    par_q   <= par_d;
  end

  // FIFO storage; pointers are reset, contents are not.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx
//   Bench for uart_frame_tx. Four instances cover different frame formats:
//     u0: 4 clk/bit, 8 data, no parity, 1 stop, depth 4
//     u1: 3 clk/bit, 8 data, even parity, 2 stop, depth 8
//     u2: 5 clk/bit, 8 data, odd parity, 1 stop, depth 2
//     u3: 4 clk/bit, 7 data, no parity, 1 stop, depth 4
//   tx/busy/done of every instance are logged once per cycle; expected
//   line waveforms are rebuilt from the frame format rules and compared.
module tb_uart_frame_tx;

  localparam int MAXC = 4000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] din [4];
  logic       vin [4];

  logic tx0, tx1, tx2, tx3;
  logic bz0, bz1, bz2, bz3;
  logic dn0, dn1, dn2, dn3;
  logic rd0, rd1, rd2, rd3;
  logic [2:0] lv0;
  logic [3:0] lv1;
  logic [1:0] lv2;
  logic [2:0] lv3;

  uart_frame_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(vin[0]), .in_ready(rd0),
    .tx(tx0), .busy(bz0), .done(dn0), .fifo_level(lv0));
  uart_frame_tx #(.CLKS_PER_BIT(3), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(8)) u1 (
    .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(vin[1]), .in_ready(rd1),
    .tx(tx1), .busy(bz1), .done(dn1), .fifo_level(lv1));
  uart_frame_tx #(.CLKS_PER_BIT(5), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .in_data(din[2]), .in_valid(vin[2]), .in_ready(rd2),
    .tx(tx2), .busy(bz2), .done(dn2), .fifo_level(lv2));
  uart_frame_tx #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst(rst), .in_data(din[3][6:0]), .in_valid(vin[3]), .in_ready(rd3),
    .tx(tx3), .busy(bz3), .done(dn3), .fifo_level(lv3));

  logic [3:0] txv, bzv, dnv, rdv;
  assign txv = {tx3, tx2, tx1, tx0};
  assign bzv = {bz3, bz2, bz1, bz0};
  assign dnv = {dn3, dn2, dn1, dn0};
  assign rdv = {rd3, rd2, rd1, rd0};

  int cyc = 0;
  logic [3:0] tx_log   [MAXC];
  logic [3:0] busy_log [MAXC];
  logic [3:0] done_log [MAXC];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      tx_log[cyc]   <= txv;
      busy_log[cyc] <= bzv;
      done_log[cyc] <= dnv;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  function automatic int level_of(input int i);
    case (i)
      0: return int'(lv0);
      1: return int'(lv1);
      2: return int'(lv2);
      default: return int'(lv3);
    endcase
  endfunction

  // Line value at bit position pos of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int pos,
                                     input int dbits, input int par);
    int ones;
    ones = 0;
    for (int k = 0; k < dbits; k++) ones += int'(b[k]);
    if (pos == 0) return 1'b0;
    if (pos <= dbits) return b[pos-1];
    if (par != 0 && pos == dbits + 1) return ((ones % 2) == 1) ^ (par == 2);
    return 1'b1;
  endfunction

  // Pushes every byte of q, holding in_valid until each one is taken.
  task automatic push_bytes(input int inst, input logic [7:0] q[$], input int depth,
                            output int first_acc, output int ncyc,
                            output int lerr, output int lmax);
    int i;
    logic acc;
    i = 0; ncyc = 0; lerr = 0; lmax = 0; first_acc = -1;
    while (i < q.size() && ncyc < 2000) begin
      vin[inst] = 1'b1;
      din[inst] = q[i];
      if (rdv[inst] !== (level_of(inst) != depth)) lerr++;
      if (level_of(inst) > lmax) lmax = level_of(inst);
      acc = rdv[inst];
      tick();
      ncyc++;
      if (acc) begin
        if (first_acc < 0) first_acc = cyc;
        i++;
      end
    end
    vin[inst] = 1'b0;
    chk($sformatf("push_all_%0d", inst), i, q.size());
  endtask

  // Checks contiguous frames for q starting at log index s, then the
  // end-of-stream idle cycle with its done pulse.
  task automatic check_frames(input int inst, input int s, input logic [7:0] q[$],
                              input int clks, input int dbits, input int par,
                              input int stops, input string tag);
    int c, errs, nbits, dones;
    nbits = 1 + dbits + ((par != 0) ? 1 : 0) + stops;
    wait_until(s + q.size() * nbits * clks + 3);
    chk({tag, "_pre_idle"}, tx_log[s-1][inst], 1'b1);
    c = s;
    dones = 0;
    foreach (q[k]) begin
      errs = 0;
      for (int p = 0; p < nbits; p++)
        for (int t = 0; t < clks; t++) begin
          if (tx_log[c][inst] !== frame_bit(q[k], p, dbits, par)) errs++;
          if (busy_log[c][inst] !== 1'b1) errs++;
          if (done_log[c][inst] !== 1'b0) dones++;
          c++;
        end
      chk($sformatf("%s_frame%0d", tag, k), errs, 0);
    end
    chk({tag, "_no_early_done"}, dones, 0);
    chk({tag, "_done"}, done_log[c][inst], 1'b1);
    chk({tag, "_end_busy"}, busy_log[c][inst], 1'b0);
    chk({tag, "_end_tx"}, tx_log[c][inst], 1'b1);
    chk({tag, "_done_1cyc"}, done_log[c+1][inst], 1'b0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] r;
    logic dup;
    int fa, nc, le, lm, s, x, errs;

    for (int i = 0; i < 4; i++) begin
      din[i] = 8'h00;
      vin[i] = 1'b0;
    end

    // Reset state
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_tx%0d", i), txv[i], 1'b1);
      chk($sformatf("rst_busy%0d", i), bzv[i], 1'b0);
      chk($sformatf("rst_done%0d", i), dnv[i], 1'b0);
      chk($sformatf("rst_level%0d", i), level_of(i), 0);
      chk($sformatf("rst_ready%0d", i), rdv[i], 1'b1);
    end
    rst = 1'b1;
    repeat (3) tick();

    // Single frame 'N'
    q = '{8'h4E};
    x = cyc;
    push_bytes(0, q, 4, fa, nc, le, lm);
    chk("single_accept_edge", fa, x + 1);
    s = fa + 1;
    check_frames(0, s, q, 4, 8, 0, 1, "single");
    chk("single_done_at_42", done_log[x + 42][0], 1'b1);
    repeat (3) tick();

    // Burst "NODE1"
    q = '{8'h4E, 8'h4F, 8'h44, 8'h45, 8'h31};
    push_bytes(0, q, 4, fa, nc, le, lm);
    chk("burst_no_stall", nc, 5);
    chk("burst_ready_rule", le, 0);
    check_frames(0, fa + 1, q, 4, 8, 0, 1, "burst");
    repeat (3) tick();

    // Full FIFO: 8 distinct random bytes into depth 4
    q.delete();
    while (q.size() < 8) begin
      r = 8'($urandom);
      dup = 1'b0;
      foreach (q[k]) if (q[k] == r) dup = 1'b1;
      if (!dup) q.push_back(r);
    end
    push_bytes(0, q, 4, fa, nc, le, lm);
    chk("full_ready_rule", le, 0);
    chk("full_level_max", lm, 4);
    check_frames(0, fa + 1, q, 4, 8, 0, 1, "full");
    repeat (3) tick();

    // Late push on the final stop-bit cycle
    q = '{8'($urandom)};
    push_bytes(0, q, 4, fa, nc, le, lm);
    s = fa + 1;
    wait_until(s + 39);
    vin[0] = 1'b1;
    din[0] = 8'($urandom);
    tick();
    vin[0] = 1'b0;
    check_frames(0, s, q, 4, 8, 0, 1, "late_a");
    q = '{din[0]};
    check_frames(0, s + 41, q, 4, 8, 0, 1, "late_b");
    repeat (3) tick();

    // Even parity, two stop bits
    q = '{8'h53, 8'($urandom), 8'($urandom), 8'($urandom)};
    push_bytes(1, q, 8, fa, nc, le, lm);
    s = fa + 1;
    check_frames(1, s, q, 3, 8, 1, 2, "even2");
    chk("even_parity_bit", tx_log[s + 9 * 3][1], 1'b0);
    chk("even_stop2_hi", tx_log[s + 11 * 3][1], 1'b1);

    // Odd parity, depth 2
    q = '{8'h53, 8'($urandom), 8'($urandom), 8'($urandom)};
    push_bytes(2, q, 2, fa, nc, le, lm);
    s = fa + 1;
    chk("odd_ready_rule", le, 0);
    chk("odd_level_max", lm, 2);
    check_frames(2, s, q, 5, 8, 2, 1, "odd");
    chk("odd_parity_bit", tx_log[s + 9 * 5][2], 1'b1);

    // 7-bit data
    q = '{8'h7F, 8'($urandom)};
    push_bytes(3, q, 4, fa, nc, le, lm);
    check_frames(3, fa + 1, q, 4, 7, 0, 1, "w7");
    repeat (3) tick();

    // Reset mid-frame during DATA bit 3 with three bytes queued
    q = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    push_bytes(0, q, 4, fa, nc, le, lm);
    s = fa + 1;
    wait_until(s + 17);
    chk("pre_rst_level", level_of(0), 3);
    rst = 1'b0;
    vin[0] = 1'b1;
    din[0] = 8'hA5;
    tick();
    x = cyc;
    chk("mid_rst_tx", tx0, 1'b1);
    chk("mid_rst_busy", bz0, 1'b0);
    chk("mid_rst_done", dn0, 1'b0);
    chk("mid_rst_level", level_of(0), 0);
    chk("mid_rst_ready", rd0, 1'b1);
    tick();
    chk("rst_push_ignored", level_of(0), 0);
    rst = 1'b1;
    vin[0] = 1'b0;
    tick();
    chk("post_rst_level", level_of(0), 0);
    wait_until(x + 14);
    errs = 0;
    for (int c = x; c < x + 12; c++)
      if (tx_log[c][0] !== 1'b1 || busy_log[c][0] !== 1'b0 || done_log[c][0] !== 1'b0) errs++;
    chk("post_rst_quiet", errs, 0);
    q = '{8'h31};
    push_bytes(0, q, 4, fa, nc, le, lm);
    check_frames(0, fa + 1, q, 4, 8, 0, 1, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
